multi_divider_clock_enable: RTL and testbench
=============================================

MULTI_DIVIDER_CLOCK_ENABLE -- requirements
Module: multi_divider_clock_enable

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of independent enable channels (1..16).
REQ-002 SHALL have parameter W, default 16, meaning divisor and counter width in bits.
REQ-003 SHALL have parameter DEFAULT_DIV, default 2, meaning the divisor every channel loads at reset (0..2^W-1).
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-006 SHALL have port sync  input  1  one-cycle pulse that realigns all channel phases.
REQ-007 SHALL have port cfg_valid  input  1  divisor-update request.
REQ-008 SHALL have port cfg_ready  output  1  the update can be accepted this cycle.
REQ-009 SHALL have port cfg_ch  input  max(1,clog2(NCH))  target channel of the update.
REQ-010 SHALL have port cfg_div  input  W  new divisor; 0 stops the channel.
REQ-011 SHALL have port en  output  NCH  per-channel clock-enable pulses.
REQ-012 SHALL have port pend  output  NCH  per-channel flag: an update is waiting to be applied.

Function
REQ-013 Each channel SHALL hold a divisor div, counter cnt (both W bits), pending divisor pdiv and pending flag pend.
REQ-014 A channel with div>=1 SHALL increment cnt each cycle and wrap cnt from div-1 to 0.
REQ-015 en[i] SHALL be high exactly in cycles where div>=1 and cnt==div-1, giving one single-cycle pulse every div cycles; div=1 SHALL give en[i] continuously high.
REQ-016 A channel with div=0 SHALL hold cnt at 0 and keep en[i] low.
REQ-017 en and pend SHALL be decoded from registered state only; there SHALL be no combinational path from any input except rst_n to en.
REQ-018 cfg_ready SHALL be ~pend[cfg_ch] when cfg_ch<NCH, and 1 otherwise.
REQ-019 An update SHALL be accepted when cfg_valid and cfg_ready are both high; an accepted update with cfg_ch>=NCH SHALL be discarded without effect.
REQ-020 An update accepted for a stopped channel (div=0) SHALL take effect at that edge: div<=cfg_div, cnt<=0; pend stays 0.
REQ-021 An update accepted for a running channel whose en is high that cycle SHALL take effect at that edge (div<=cfg_div, cnt<=0); pend stays 0.
REQ-022 Otherwise an accepted update SHALL set pdiv<=cfg_div, pend<=1; it SHALL then be applied (div<=pdiv, cnt<=0, pend<=0) at the edge ending the channel's next en cycle or at the next sync, whichever comes first.
REQ-023 The current period SHALL never be truncated or stretched by a divisor update, except by sync.
REQ-024 sync high SHALL, at that edge, set cnt<=0 on every channel and apply any pending divisor; en in the sync cycle SHALL still reflect the pre-sync state.
REQ-025 sync and an accepted update in the same cycle SHALL result in the channel taking cfg_div with cnt=0 and pend=0.
REQ-026 cnt arithmetic SHALL be modulo 2^W; div=2^W-1 SHALL give one pulse per 2^W-1 cycles.

Reset
REQ-027 While rst_n is low at a clock edge, every channel SHALL load div=DEFAULT_DIV, cnt=0, pdiv=0, pend=0.
REQ-028 en SHALL be forced to 0 while rst_n is low, including with DEFAULT_DIV=1.
REQ-029 A reset asserted mid-period or with updates pending SHALL discard all pending updates and phase.
REQ-030 After rst_n rises, with DEFAULT_DIV=D>=1, en[i] SHALL first pulse in the D-th cycle, where the first cycle after release is cycle 1.

Structure
REQ-031 A shared package clock_enable_pkg SHALL hold the channel-index width function and the stopped-channel constant (0).
REQ-032 Per-channel state and update logic SHALL be one sub-module, divider_channel, instantiated NCH times; the top SHALL hold only cfg_ch decode, cfg_ready mux and sync fan-out.

Verification
REQ-033 Reset release with DEFAULT_DIV=4, NCH=4 -> every en pulses in cycles 4, 8, 12; pend=0; cfg_ready=1.
REQ-034 Channel 1 running div=4: at cnt=1 write cfg_div=3 -> pend[1]=1 and cfg_ready low for cfg_ch=1; the period completes at length 4; then pulses every 3 cycles; pend[1] clears.
REQ-035 Write cfg_div=0 to channel 2, then cfg_div=5 -> channel 2 stops after its current period; the restart write applies at once (no pend); the first pulse is 5 cycles later.
REQ-036 Channels with div=3 and div=5 drifted; pulse sync once -> both cnt=0; next pulses are 3 and 5 cycles later; a pending update on channel 0 is applied at the sync.
REQ-037 Update landing in the en cycle, sync+cfg same cycle, and cfg_ch=5 with NCH=4 -> immediate apply, cfg_div wins, and no state change respectively.
REQ-038 Assert rst_n low mid-period with pend set, and also set div=1 -> en is low throughout reset, pend clears, and the restart matches REQ-030.

Source files
------------

// File: rtl/clock_enable_pkg.sv
// Shared definitions for the multi-channel clock-enable divider.
package clock_enable_pkg;

  // Divisor value that parks a channel: counter held at zero, no enables.
  localparam int STOP_DIV = 0;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_divider_clock_enable_if.sv
// Divisor-update handshake between a configuration master and the divider.
interface multi_divider_clock_enable_if import clock_enable_pkg::*; #(
  parameter int NCH = 4,
  parameter int W   = 16
) ();

  localparam int CW = ch_width(NCH);

  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch;
  logic [W-1:0]  cfg_div;

  modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);

endinterface

// File: rtl/divider_channel.sv
// One clock-enable channel: divisor, phase counter and a one-deep pending update.
module divider_channel import clock_enable_pkg::*; #(
  parameter int W           = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sync,
  input  logic         upd,
  input  logic [W-1:0] upd_div,
  output logic         en,
  output logic         pend
);

  logic [W-1:0] div_r;
  logic [W-1:0] cnt_r;
  logic [W-1:0] pdiv_r;
  logic         pend_r;

  logic [W-1:0] div_s;
  logic [W-1:0] cnt_s;
  logic [W-1:0] pdiv_s;
  logic         pend_s;
  logic         stopped_s;
  logic         hit_s;

  assign stopped_s = (div_r == W'(STOP_DIV));
  assign hit_s     = !stopped_s && (cnt_r == (div_r - W'(1'b1)));

  // Outputs come from registered state only; reset masks en so div=1 stays quiet.
  assign en   = rst_n & hit_s;
  assign pend = pend_r;

  // Next-state: sync realigns, updates at a period boundary apply at once, others wait.
  always_comb begin
    div_s  = div_r;
    cnt_s  = cnt_r;
    pdiv_s = pdiv_r;
    pend_s = pend_r;
    if (sync) begin
      cnt_s  = {W{1'b0}};
      pend_s = 1'b0;
      if (upd) begin
        div_s = upd_div;
      end else if (pend_r) begin
        div_s = pdiv_r;
      end else begin
        div_s = div_r;
      end
    end else if (upd && (stopped_s || hit_s)) begin
      div_s  = upd_div;
      cnt_s  = {W{1'b0}};
      pend_s = 1'b0;
    end else if (upd) begin
      // Mid-period on a running channel: park it, keep counting undisturbed.
      pdiv_s = upd_div;
      pend_s = 1'b1;
      cnt_s  = cnt_r + W'(1'b1);
    end else if (hit_s) begin
      cnt_s = {W{1'b0}};
      if (pend_r) begin
        div_s  = pdiv_r;
        pend_s = 1'b0;
      end else begin
        div_s  = div_r;
        pend_s = pend_r;
      end
    end else if (stopped_s) begin
      cnt_s = {W{1'b0}};
    end else begin
      cnt_s = cnt_r + W'(1'b1);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_r  <= W'(DEFAULT_DIV);
      cnt_r  <= {W{1'b0}};
      pdiv_r <= {W{1'b0}};
      pend_r <= 1'b0;
    end else begin
      div_r  <= div_s;
      cnt_r  <= cnt_s;
      pdiv_r <= pdiv_s;
      pend_r <= pend_s;
    end
  end

endmodule

// File: rtl/multi_divider_clock_enable.sv
// NCH independent clock-enable dividers sharing one update port and one sync input.
module multi_divider_clock_enable import clock_enable_pkg::*; #(
  parameter int NCH         = 4,
  parameter int W           = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sync,
  multi_divider_clock_enable_if.slave  cfg,
  output logic [NCH-1:0]               en,
  output logic [NCH-1:0]               pend
);

  localparam int CW   = ch_width(NCH);
  localparam int NPAD = 2 ** CW;

  logic [NPAD-1:0] pend_pad_s;
  logic            ready_s;
  logic [NCH-1:0]  upd_s;

  // Ready mux: indices past NCH read a zero pad, so they are always ready.
  always_comb begin
    pend_pad_s          = {NPAD{1'b0}};
    pend_pad_s[NCH-1:0] = pend;
    ready_s             = ~pend_pad_s[cfg.cfg_ch];
  end

  assign cfg.cfg_ready = ready_s;

  // Channel decode: an accepted out-of-range index matches nothing and is dropped.
  always_comb begin
    upd_s = {NCH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      upd_s[i] = cfg.cfg_valid & ready_s & (cfg.cfg_ch == CW'(i));
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    divider_channel #(
      .W           (W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .sync    (sync),
      .upd     (upd_s[i]),
      .upd_div (cfg.cfg_div),
      .en      (en[i]),
      .pend    (pend[i])
    );
  end

endmodule

// File: tb/tb_multi_divider_clock_enable.sv
// Directed bench: a cycle table plus hand sequences for sync, reset and out-of-range writes.
module tb_multi_divider_clock_enable;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sync;
  logic       sync1;
  logic [3:0] en;
  logic [3:0] pend;
  logic [2:0] en1;
  logic [2:0] pend1;

  // Values the next cyc() call applies to the small second instance.
  logic       q1_v;
  logic [1:0] q1_ch;
  logic [3:0] q1_d;

  int n_cmp = 0;
  int n_bad = 0;

  multi_divider_clock_enable_if #(.NCH(4), .W(16)) cfg ();
  multi_divider_clock_enable_if #(.NCH(3), .W(4))  cfg1 ();

  multi_divider_clock_enable #(.NCH(4), .W(16), .DEFAULT_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .sync(sync), .cfg(cfg), .en(en), .pend(pend)
  );

  multi_divider_clock_enable #(.NCH(3), .W(4), .DEFAULT_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sync(sync1), .cfg(cfg1), .en(en1), .pend(pend1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        sy;
    logic        v;
    logic [1:0]  ch;
    logic [15:0] d;
    logic [3:0]  e_en;
    logic [3:0]  e_pend;
    logic        e_rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(input logic r, input logic s, input logic v, input logic [1:0] ch,
                               input logic [15:0] d, input logic [3:0] ee, input logic [3:0] ep,
                               input logic er);
    vec_t x;
    x.rst = r; x.sy = s; x.v = v; x.ch = ch; x.d = d;
    x.e_en = ee; x.e_pend = ep; x.e_rdy = er;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, leave outputs settled for checking.
  task automatic cyc(input logic r, input logic s, input logic v, input logic [1:0] ch,
                     input logic [15:0] d);
    @(negedge clk);
    rst_n = r; sync = s;
    cfg.cfg_valid = v; cfg.cfg_ch = ch; cfg.cfg_div = d;
    cfg1.cfg_valid = q1_v; cfg1.cfg_ch = q1_ch; cfg1.cfg_div = q1_d;
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int j = 0; j < n; j++) begin
      cyc(1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
      chk($sformatf("rst%0d en", j), en, 32'd0);
      chk($sformatf("rst%0d en1", j), en1, 32'd0);
      if (j > 0) begin
        chk($sformatf("rst%0d pend", j), pend, 32'd0);
        chk($sformatf("rst%0d pend1", j), pend1, 32'd0);
      end
    end
  endtask

  logic [3:0] exp_en_c [1:20];
  logic [3:0] exp_pd_c [1:20];
  logic [3:0] exp_en_d [1:13];

  initial begin
    rst_n = 1'b0; sync = 1'b0; sync1 = 1'b0;
    cfg.cfg_valid = 1'b0; cfg.cfg_ch = 2'd0; cfg.cfg_div = 16'd0;
    cfg1.cfg_valid = 1'b0; cfg1.cfg_ch = 2'd0; cfg1.cfg_div = 4'd0;
    q1_v = 1'b0; q1_ch = 2'd0; q1_d = 4'd0;

    // Reset release (pulses at 4, 8, 12), then channel 1 retimed from 4 to 3 mid-period.
    tbl.push_back(row(0, 0, 0, 2'd0, 16'd0, 4'h0, 4'h0, 1));
    for (int k = 1; k <= 13; k++) begin
      tbl.push_back(row(1, 0, 0, 2'd0, 16'd0, (k % 4 == 0) ? 4'hF : 4'h0, 4'h0, 1));
    end
    tbl.push_back(row(1, 0, 1, 2'd1, 16'd3, 4'h0, 4'h0, 1));  // 14: cnt=1, parks div 3
    tbl.push_back(row(1, 0, 1, 2'd1, 16'd7, 4'h0, 4'h2, 0));  // 15: not ready, ignored
    tbl.push_back(row(1, 0, 0, 2'd1, 16'd0, 4'hF, 4'h2, 0));  // 16: period ends at length 4
    tbl.push_back(row(1, 0, 0, 2'd1, 16'd0, 4'h0, 4'h0, 1));  // 17
    tbl.push_back(row(1, 0, 0, 2'd1, 16'd0, 4'h0, 4'h0, 1));  // 18
    tbl.push_back(row(1, 0, 0, 2'd1, 16'd0, 4'h2, 4'h0, 1));  // 19
    tbl.push_back(row(1, 0, 0, 2'd1, 16'd0, 4'hD, 4'h0, 1));  // 20
    tbl.push_back(row(1, 0, 0, 2'd1, 16'd0, 4'h0, 4'h0, 1));  // 21
    tbl.push_back(row(1, 0, 0, 2'd1, 16'd0, 4'h2, 4'h0, 1));  // 22
    tbl.push_back(row(1, 0, 0, 2'd1, 16'd0, 4'h0, 4'h0, 1));  // 23
    tbl.push_back(row(1, 0, 0, 2'd1, 16'd0, 4'hD, 4'h0, 1));  // 24
    tbl.push_back(row(1, 0, 0, 2'd1, 16'd0, 4'h2, 4'h0, 1));  // 25

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].sy, tbl[i].v, tbl[i].ch, tbl[i].d);
      chk($sformatf("tbl[%0d] en", i), en, tbl[i].e_en);
      chk($sformatf("tbl[%0d] pend", i), pend, tbl[i].e_pend);
      chk($sformatf("tbl[%0d] rdy", i), cfg.cfg_ready, tbl[i].e_rdy);
    end

    // Stop channel 2, then restart it with 5.
    do_reset(2);
    for (int k = 1; k <= 19; k++) begin
      case (k)
        1:       cyc(1'b1, 1'b0, 1'b1, 2'd2, 16'd0);
        9:       cyc(1'b1, 1'b0, 1'b1, 2'd2, 16'd5);
        default: cyc(1'b1, 1'b0, 1'b0, 2'd2, 16'd0);
      endcase
      chk($sformatf("stop k%0d en2", k), en[2], (k == 4 || k == 14 || k == 19) ? 32'd1 : 32'd0);
      chk($sformatf("stop k%0d pend2", k), pend[2], (k >= 2 && k <= 4) ? 32'd1 : 32'd0);
    end

    // Channels at 3 and 5 drift against 4; sync realigns and applies channel 0's pending 2.
    exp_en_c = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h2, 4'h9, 4'h4, 4'h2,
                 4'h0, 4'h1, 4'h2, 4'h9, 4'h4, 4'h3, 4'h0, 4'h9, 4'h2, 4'h5};
    exp_pd_c = '{4'h0, 4'h2, 4'h6, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1,
                 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    do_reset(2);
    for (int k = 1; k <= 20; k++) begin
      case (k)
        1:       cyc(1'b1, 1'b0, 1'b1, 2'd1, 16'd3);
        2:       cyc(1'b1, 1'b0, 1'b1, 2'd2, 16'd5);
        9:       cyc(1'b1, 1'b0, 1'b1, 2'd0, 16'd2);
        10:      cyc(1'b1, 1'b1, 1'b0, 2'd0, 16'd0);
        default: cyc(1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
      endcase
      chk($sformatf("sync k%0d en", k), en, exp_en_c[k]);
      chk($sformatf("sync k%0d pend", k), pend, exp_pd_c[k]);
    end

    // Update in the en cycle applies at once; sync plus update takes the new divisor.
    exp_en_d = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h8, 4'h0, 4'h0, 4'h8, 4'h1,
                 4'hE, 4'h0, 4'h9};
    do_reset(2);
    for (int k = 1; k <= 13; k++) begin
      case (k)
        4:       cyc(1'b1, 1'b0, 1'b1, 2'd3, 16'd2);
        7:       cyc(1'b1, 1'b1, 1'b1, 2'd0, 16'd3);
        default: cyc(1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
      endcase
      chk($sformatf("imm k%0d en", k), en, exp_en_d[k]);
      chk($sformatf("imm k%0d pend", k), pend, 32'd0);
      chk($sformatf("imm k%0d rdy", k), cfg.cfg_ready, 32'd1);
    end

    // Reset mid-period with an update pending and a channel at div 1.
    do_reset(2);
    for (int k = 1; k <= 6; k++) begin
      case (k)
        4:       cyc(1'b1, 1'b0, 1'b1, 2'd2, 16'd1);
        5:       cyc(1'b1, 1'b0, 1'b1, 2'd0, 16'd7);
        default: cyc(1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
      endcase
    end
    chk("pre-rst en", en, 32'h4);
    chk("pre-rst pend", pend, 32'h1);
    do_reset(3);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
      chk($sformatf("restart k%0d en", k), en, (k == 4 || k == 8) ? 32'hF : 32'h0);
      chk($sformatf("restart k%0d pend", k), pend, 32'd0);
      chk($sformatf("restart k%0d en1", k), en1, 32'h7);
    end

    // Second instance: out-of-range write is dropped, then the widest divisor (15).
    do_reset(2);
    for (int k = 1; k <= 33; k++) begin
      q1_v  = (k == 1 || k == 2) ? 1'b1 : 1'b0;
      q1_ch = (k == 1) ? 2'd3 : 2'd0;
      q1_d  = (k == 1) ? 4'd5 : 4'd15;
      cyc(1'b1, 1'b0, 1'b0, 2'd0, 16'd0);
      if (k == 1) begin
        chk("oor rdy1", cfg1.cfg_ready, 32'd1);
      end
      chk($sformatf("wide k%0d en1", k), en1,
          (k <= 2 || k == 17 || k == 32) ? 32'h7 : 32'h6);
      chk($sformatf("wide k%0d pend1", k), pend1, 32'd0);
    end
    q1_v = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 2'd0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
